uart_tx_fifo: RTL and testbench

Word buffer sitting directly upstream of `uart_tx`, decoupling a bursty producer from the serial transmitter. Accepts words via a valid/ready write port, stores up to `DEPTH` of them, and presents the oldest word to the transmitter via the `uart_tx_if` signals `data`, `can_send_next_word` and `ready`. A word is popped only once the transmitter has actually latched it, detected as a falling edge on the transmitter's `ready`.

---
 rtl/uart_tx_fifo.sv | 98 +++++++++
 tb/tb_uart_tx_fifo.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Word FIFO feeding uart_tx. A word is popped when the transmitter's ready falls.
// Optional sticky write-overflow flag: define UART_TX_FIFO_OVERFLOW_EN.
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   output logic [WIDTH-1:0]         tx_data,
   output logic                     tx_can_send_next_word,
   input  logic                     tx_ready,
   output logic [$clog2(DEPTH):0]   count
`ifdef UART_TX_FIFO_OVERFLOW_EN
   ,
   output logic                     overflow
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ready_q, ready_d;
   logic             push, pop;

   assign wr_ready              = (count_q != CW'(DEPTH));
   assign tx_can_send_next_word = (count_q != '0);
   assign tx_data               = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign count                 = count_q;

   // Only a falling ready means the transmitter latched the head; ready high
   // during the stop bit is not consumption.
   always_comb begin
      push     = wr_valid && wr_ready;
      pop      = ready_q && !tx_ready && (count_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ready_d  = tx_ready;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ready_q  <= ready_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

`ifdef UART_TX_FIFO_OVERFLOW_EN
   logic overflow_q, overflow_d;

   always_comb begin
      overflow_d = overflow_q | (wr_valid && !wr_ready);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo, including a loopback through
// a behavioural transmitter model (4 clocks per bit).
module tb_uart_tx_fifo;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] wr_data = 8'h00;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic [7:0] tx_data;
   logic       tx_can_send_next_word;
   logic       tx_ready;
   logic [4:0] count;
`ifdef UART_TX_FIFO_OVERFLOW_EN
   logic       overflow;
`endif

   logic       drv_ready = 1'b1;
   logic       loop_en = 1'b0;
   logic       m_ready;
   logic       m_busy;
   logic       line;
   logic [9:0] m_shift;
   logic [1:0] m_cnt;
   logic [3:0] m_bit;

   int         vectors = 0;
   int         miscompares = 0;
   int         bad_stops = 0;
   logic [7:0] rx_q[$];
   logic [7:0] model_q[$];

   assign tx_ready = loop_en ? m_ready : drv_ready;

   always #5 clock = ~clock;

   uart_tx_fifo #(.WIDTH(8), .DEPTH(16)) dut (
      .clock                 (clock),
      .reset                 (reset),
      .wr_data               (wr_data),
      .wr_valid              (wr_valid),
      .wr_ready              (wr_ready),
      .tx_data               (tx_data),
      .tx_can_send_next_word (tx_can_send_next_word),
      .tx_ready              (tx_ready),
      .count                 (count)
`ifdef UART_TX_FIFO_OVERFLOW_EN
      ,
      .overflow              (overflow)
`endif
   );

   // Transmitter model: latches when idle and data is offered, drops ready,
   // then raises ready again for the stop bit while still busy.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_busy  <= 1'b0;
         m_ready <= 1'b1;
         line    <= 1'b1;
         m_cnt   <= 2'd0;
         m_bit   <= 4'd0;
         m_shift <= 10'h3ff;
      end else if (!m_busy) begin
         if (loop_en && tx_can_send_next_word) begin
            m_shift <= {1'b1, tx_data, 1'b0};
            m_busy  <= 1'b1;
            m_ready <= 1'b0;
            line    <= 1'b0;
            m_cnt   <= 2'd0;
            m_bit   <= 4'd0;
         end
      end else if (m_cnt == 2'd3) begin
         m_cnt <= 2'd0;
         if (m_bit == 4'd9) begin
            m_busy <= 1'b0;
         end else begin
            m_bit <= m_bit + 4'd1;
            line  <= m_shift[m_bit + 4'd1];
            if (m_bit + 4'd1 == 4'd9) begin
               m_ready <= 1'b1;
            end
         end
      end else begin
         m_cnt <= m_cnt + 2'd1;
      end
   end

   // Line receiver: samples each bit half a clock after its start.
   initial begin
      logic [7:0] rx_byte;
      forever begin
         @(negedge clock);
         if (loop_en && line === 1'b0) begin
            rx_byte = 8'h00;
            for (int k = 0; k < 8; k++) begin
               repeat (4) @(negedge clock);
               rx_byte[k] = line;
            end
            repeat (4) @(negedge clock);
            if (line !== 1'b1) bad_stops++;
            rx_q.push_back(rx_byte);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, observed running expected finished");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic rdy);
      wr_valid  = valid;
      wr_data   = data;
      drv_ready = rdy;
      tick();
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      logic do_push, do_pop;
      int   pre;

      // Reset and idle with ready held high
      repeat (3) tick();
      reset = 1'b0;
      checkOutput("rst_wr_ready", wr_ready, 1);
      checkOutput("rst_count", count, 0);
      checkOutput("rst_can_send", tx_can_send_next_word, 0);
      checkOutput("rst_tx_data", tx_data, 0);
`ifdef UART_TX_FIFO_OVERFLOW_EN
      checkOutput("rst_overflow", overflow, 0);
`endif
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b1);
         checkOutput("idle_count", count, 0);
         checkOutput("idle_can_send", tx_can_send_next_word, 0);
      end

      // Single word, then ready falls one cycle after it became visible
      applyStimulus(1'b1, 8'hA5, 1'b1);
      checkOutput("one_count", count, 1);
      checkOutput("one_tx_data", tx_data, 8'hA5);
      checkOutput("one_can_send", tx_can_send_next_word, 1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("one_latch_count", count, 1);
      drv_ready = 1'b0;
      #1;
      checkOutput("one_pre_pop_count", count, 1);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("one_pop_count", count, 0);
      checkOutput("one_pop_can_send", tx_can_send_next_word, 0);
      checkOutput("one_pop_tx_data", tx_data, 0);

      // Fill to full, refused 17th write, then drain in order
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 8'(i), 1'b0);
         checkOutput("fill_head", tx_data, 8'h00);
      end
      checkOutput("full_count", count, 16);
      checkOutput("full_wr_ready", wr_ready, 0);
      applyStimulus(1'b1, 8'hFF, 1'b0);
      checkOutput("refused_count", count, 16);
`ifdef UART_TX_FIFO_OVERFLOW_EN
      checkOutput("overflow_set", overflow, 1);
`endif
      wr_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         checkOutput("drain_head", tx_data, 8'(i));
         applyStimulus(1'b0, 8'h00, 1'b1);
         checkOutput("drain_head_stable", tx_data, 8'(i));
         applyStimulus(1'b0, 8'h00, 1'b0);
         if (i == 0) begin
            checkOutput("recover_wr_ready", wr_ready, 1);
            checkOutput("recover_count", count, 15);
         end
      end
      checkOutput("drain_count", count, 0);
      checkOutput("drain_can_send", tx_can_send_next_word, 0);
`ifdef UART_TX_FIFO_OVERFLOW_EN
      checkOutput("overflow_sticky", overflow, 1);
`endif

      // Loopback through the transmitter model
      applyStimulus(1'b0, 8'h00, 1'b1);
      loop_en = 1'b1;
      applyStimulus(1'b1, 8'h55, 1'b1);
      applyStimulus(1'b1, 8'h0F, 1'b1);
      applyStimulus(1'b1, 8'hC3, 1'b1);
      wr_valid = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (rx_q.size() >= 3 && count == 5'd0 && !m_busy) break;
         tick();
      end
      repeat (30) tick();
      checkOutput("loop_frames", rx_q.size(), 3);
      checkOutput("loop_byte0", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h55);
      checkOutput("loop_byte1", (rx_q.size() > 1) ? rx_q[1] : 8'hxx, 8'h0F);
      checkOutput("loop_byte2", (rx_q.size() > 2) ? rx_q[2] : 8'hxx, 8'hC3);
      checkOutput("loop_stop_bits", bad_stops, 0);
      checkOutput("loop_count", count, 0);
      drv_ready = 1'b1;
      loop_en = 1'b0;
      tick();

      // Simultaneous push and pop at count 3
      applyStimulus(1'b1, 8'h30, 1'b1);
      applyStimulus(1'b1, 8'h31, 1'b1);
      applyStimulus(1'b1, 8'h32, 1'b1);
      checkOutput("sim_pre_count", count, 3);
      checkOutput("sim_pre_head", tx_data, 8'h30);
      applyStimulus(1'b1, 8'h33, 1'b0);
      checkOutput("sim_count", count, 3);
      checkOutput("sim_head", tx_data, 8'h31);
      model_q = '{8'h31, 8'h32, 8'h33};

      // Mixed operations across pointer wrap, tracked against a queue model
      for (int i = 0; i < 40; i++) begin
         do_push = (i % 3) != 2;
         do_pop  = (i % 2) == 0;
         applyStimulus(1'b0, 8'h00, 1'b1);
         applyStimulus(do_push, 8'(8'h40 + i), !do_pop);
         pre = model_q.size();
         if (do_pop && pre > 0) void'(model_q.pop_front());
         if (do_push && pre < 16) model_q.push_back(8'(8'h40 + i));
         checkOutput("mix_count", count, model_q.size());
         checkOutput("mix_head", tx_data, (model_q.size() > 0) ? model_q[0] : 8'h00);
      end
      wr_valid = 1'b0;

      // Asynchronous reset mid-stream at count 5
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 8'(8'h70 + i), 1'b1);
      end
      wr_valid = 1'b0;
      checkOutput("midrst_pre_count", count, 5);
      #3;
      reset = 1'b1;
      #1;
      checkOutput("midrst_count", count, 0);
      checkOutput("midrst_can_send", tx_can_send_next_word, 0);
      checkOutput("midrst_wr_ready", wr_ready, 1);
      checkOutput("midrst_tx_data", tx_data, 0);
`ifdef UART_TX_FIFO_OVERFLOW_EN
      checkOutput("midrst_overflow", overflow, 0);
`endif
      tick();
      reset = 1'b0;
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("post_rst_count", count, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
